// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: valid/ready word intake, elaboration-time
// bit period, data width, parity mode and stop-bit count; TxD is registered.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 TxD,
    output logic                 busy
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [BAUD_W-1:0]      r_baud;
    logic [BIT_W-1:0]       r_bit;
    logic [DATA_BITS-1:0]   r_shreg;
    logic                   r_par;
    logic                   r_txd;
    logic                   r_tx_ready;
    logic                   r_busy;

    state_t                 w_state_nxt;
    logic [BAUD_W-1:0]      w_baud_nxt;
    logic [BIT_W-1:0]       w_bit_nxt;
    logic [DATA_BITS-1:0]   w_shreg_nxt;
    logic                   w_par_nxt;
    logic                   w_txd_nxt;
    logic                   w_baud_wrap;
    logic                   w_par_calc;
    logic                   w_xfer;

    assign w_baud_wrap = (r_baud == BAUD_LAST);
    assign w_xfer      = tx_valid && r_tx_ready;

    // Odd parity inverts the XOR so the total count of ones is odd.
    assign w_par_calc  = (PARITY == 1) ? ~(^tx_data) : (^tx_data);

    // Next-state, counters and line level for the coming clock.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_par_nxt   = r_par;
        w_txd_nxt   = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_START;
                    w_shreg_nxt = tx_data;
                    w_par_nxt   = w_par_calc;
                end
            end
            ST_START: begin
                w_txd_nxt = 1'b0;
                if (w_baud_wrap) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_txd_nxt = r_shreg[0];
                if (w_baud_wrap) begin
                    w_shreg_nxt = r_shreg >> 1;
                    if (r_bit == DATA_LAST) begin
                        w_state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                w_txd_nxt = r_par;
                if (w_baud_wrap) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_baud_wrap) begin
                    if (r_bit == STOP_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Baud counter only runs inside a frame and restarts with each transfer.
        if (r_state == ST_IDLE) begin
            w_baud_nxt = '0;
        end else begin
            w_baud_nxt = w_baud_wrap ? '0 : r_baud + BAUD_W'(1);
        end

        if (w_state_nxt != r_state) begin
            w_bit_nxt = '0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit      <= w_bit_nxt;
            r_shreg    <= w_shreg_nxt;
            r_par      <= w_par_nxt;
            r_txd      <= w_txd_nxt;
            r_tx_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign tx_ready = r_tx_ready;
    assign TxD      = r_txd;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four frame formats run in parallel, each
// with its own handshake model, expected-frame queue and line monitor.
module tb_uart_tx_cfg;

    localparam int N_INST = 4;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_cpb(input int g);
        return (g == 3) ? 2 : 4;
    endfunction
    function automatic int cfg_db(input int g);
        case (g)
            2:       return 7;
            3:       return 5;
            default: return 8;
        endcase
    endfunction
    function automatic int cfg_par(input int g);
        case (g)
            0:       return 0;
            2:       return 1;
            default: return 2;
        endcase
    endfunction
    function automatic int cfg_sb(input int g);
        return (g >= 2) ? 2 : 1;
    endfunction

    // Line level of frame bit b: start, data LSB first, optional parity, stops.
    function automatic logic exp_lvl(input int w, input int b, input int db, input int par);
        int ones;
        ones = 0;
        for (int i = 0; i < db; i++) ones += (w >> i) & 1;
        if (b == 0) return 1'b0;
        if (b <= db) return ((w >> (b - 1)) & 1) != 0;
        if (par != 0 && b == db + 1) return (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t actual=%0d expected=%0d", name, g, $time, act, exp);
        end
    endtask

    for (genvar G = 0; G < N_INST; G++) begin : g_inst
        localparam int CPB = cfg_cpb(G);
        localparam int DB  = cfg_db(G);
        localparam int PAR = cfg_par(G);
        localparam int SB  = cfg_sb(G);
        localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
        localparam int L   = NB * CPB;
        localparam int MSK = (1 << DB) - 1;

        typedef struct {
            int w;
            int t;
        } exp_t;

        exp_t exp_q[$];
        logic rst_n;
        logic tx_valid;
        logic rdy;
        logic txd;
        logic busy;
        logic [DB-1:0] tx_data;
        int last_t  = -1000;
        int acc_cnt = 0;
        int rst_gen = 0;

        uart_tx_cfg #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB),
            .PARITY      (PAR),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk     (clk),
            .reset   (rst_n),
            .tx_valid(tx_valid),
            .tx_data (tx_data),
            .tx_ready(rdy),
            .TxD     (txd),
            .busy    (busy)
        );

        // Reference: a word is taken when valid and the line has been idle a clock.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                last_t = -1000;
                exp_q.delete();
                rst_gen++;
            end else if (tx_valid && (cyc >= last_t + L)) begin
                last_t = cyc + 1;
                exp_q.push_back('{w: int'(tx_data), t: cyc + 1});
                acc_cnt++;
            end
        end

        // Handshake/status expectations every cycle.
        always @(negedge clk) begin
            logic eb;
            eb = (cyc >= last_t) && (cyc < last_t + L);
            chk("busy", G, busy, eb);
            chk("tx_ready", G, rdy, !eb);
            if (!eb) chk("txd_idle", G, txd, 1);
        end

        // Monitor: decode each frame on the line and compare with the queue head.
        initial begin : mon
            exp_t e;
            int gen;
            bit abort;
            forever begin
                @(negedge clk);
                if (rst_n && txd == 1'b0) begin
                    gen = rst_gen;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", G, 1, 0);
                        for (int k = 0; k < L && txd == 1'b0; k++) @(negedge clk);
                    end else begin
                        e = exp_q.pop_front();
                        chk("start_latency", G, cyc - e.t, 1);
                        abort = 1'b0;
                        for (int b = 0; b < NB && !abort; b++) begin
                            for (int c = 0; c < CPB && !abort; c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (rst_gen != gen) abort = 1'b1;
                                else chk($sformatf("bit%0d_w%0h", b, e.w), G, txd,
                                         exp_lvl(e.w, b, DB, PAR));
                            end
                        end
                    end
                end
            end
        end

        task automatic send(input int w, input bit hold);
            int a0;
            int k;
            a0 = acc_cnt;
            tx_valid = 1'b1;
            tx_data  = DB'(w);
            k = 0;
            while (acc_cnt == a0 && k < 3 * L) begin
                @(negedge clk);
                k++;
            end
            if (acc_cnt == a0) chk("accept_timeout", G, 0, 1);
            if (!hold || acc_cnt == a0) begin
                tx_valid = 1'b0;
                tx_data  = DB'($urandom);
            end
        endtask

        task automatic wait_idle();
            int k;
            k = 0;
            while (cyc < last_t + L + 1 && k < 4 * L) begin
                @(negedge clk);
                k++;
            end
            chk("idle_timeout", G, (cyc >= last_t + L + 1) ? 1 : 0, 1);
        endtask

        task automatic check_reset_state(input string tag);
            chk({tag, "_txd"}, G, txd, 1);
            chk({tag, "_busy"}, G, busy, 0);
            chk({tag, "_ready"}, G, rdy, 1);
        endtask

        initial begin : stim
            tx_valid = 1'b0;
            tx_data  = '0;
            rst_n    = 1'b1;
            #1 rst_n = 1'b0;
            #2 check_reset_state("por");
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
            @(negedge clk);

            if (G == 0) begin
                send(32'h55, 1'b0);
            end else if (G == 1) begin
                send(32'h07, 1'b0);
                wait_idle();
                send(32'h03, 1'b0);
            end else if (G == 2) begin
                send(32'h00, 1'b0);
            end else begin
                send(32'h15, 1'b0);
            end
            wait_idle();

            // Back-to-back with valid held across the boundary.
            send(32'hA5 & MSK, 1'b1);
            send(32'h3C & MSK, 1'b0);
            wait_idle();

            // Valid pulse and data churn while busy must be ignored.
            send(32'h5A & MSK, 1'b0);
            repeat (2 * CPB) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = '1;
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = DB'($urandom);
            wait_idle();

            // Asynchronous reset in the middle of the data bits.
            send(32'h3C & MSK, 1'b0);
            repeat (3 * CPB) @(posedge clk);
            #1 rst_n = 1'b0;
            #1 check_reset_state("midframe_rst");
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
            @(negedge clk);
            send(32'h81 & MSK, 1'b0);
            wait_idle();

            for (int i = 0; i < 24; i++) begin
                bit hold;
                hold = 1'($urandom_range(0, 1));
                send(int'($urandom) & MSK, hold);
                if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            tx_valid = 1'b0;
            wait_idle();
            repeat (4) @(negedge clk);
            chk("queue_drained", G, exp_q.size(), 0);
            n_done++;
        end
    end

    initial begin : main
        int k;
        k = 0;
        while (n_done < N_INST && k < 50000) begin
            @(negedge clk);
            k++;
        end
        if (n_done < N_INST) begin
            checks++;
            errors++;
            $display("FAIL run_timeout done=%0d expected=%0d", n_done, N_INST);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 9600-baud transmitter. Frame format is set at elaboration: bit period in clocks, data width, parity mode and stop-bit count. Bytes are accepted over a valid/ready handshake, so an upstream FIFO or command sequencer can stream frames back to back. Output drives the board TX pin directly.

Parameters:
CLKS_PER_BIT, 10416, clock cycles per serial bit (100 MHz / 9600); legal range >= 2.
DATA_BITS, 8, data bits per frame, LSB first; legal 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  asynchronous active-low reset.
tx_valid  input  1  upstream has a word on tx_data.
tx_data  input  DATA_BITS  word to send.
tx_ready  output  1  block can accept a word this cycle.
TxD  output  1  serial line, idle high.
busy  output  1  frame in progress (any state except IDLE).

Behaviour:
- Reset (reset == 0, async): state IDLE, TxD = 1, tx_ready = 1, busy = 0, bit and baud counters cleared, shift register cleared. Applies immediately, also mid-frame; the partial frame is abandoned. No glitch low on TxD.
- Handshake: transfer occurs on a posedge where tx_valid && tx_ready. tx_ready = 1 only in IDLE. tx_data is captured into a shift register on the transfer edge. Later changes to tx_data are ignored. tx_valid while busy is ignored, and the word is not consumed. No combinational path from tx_valid to tx_ready.
- Parity bit is computed from the captured word at the transfer edge. Even parity: the parity bit is the XOR of the data bits. Odd parity: the parity bit is the inverted XOR of the data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on transfer.
  - START -> DATA after one bit period.
  - DATA -> PARITY after DATA_BITS periods if PARITY != 0, else DATA -> STOP.
  - PARITY -> STOP after one period.
  - STOP -> IDLE after STOP_BITS periods.
- TxD levels by state: IDLE 1, START 0, DATA shreg[0] (shift right once per bit period), PARITY parity bit, STOP 1. TxD is registered.
- Timing: the baud counter restarts at 0 on the transfer edge; there is no free-running divider.
  - TxD falls on the clock edge after the transfer edge (latency 1 clock).
  - Every bit, including each stop bit, lasts exactly CLKS_PER_BIT clocks.
  - Baud counter width is clog2(CLKS_PER_BIT); it wraps from CLKS_PER_BIT-1 to 0 and advances the bit.
- Frame length is (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT clocks.
- The block returns to IDLE with tx_ready = 1 on the edge that ends the last stop bit.
- Back to back: if tx_valid is held, the next transfer occurs on that IDLE cycle. The start bit follows one clock later, so the inter-frame idle gap is exactly 1 clock beyond the stop bits.
- Bit counter counts DATA bits and stop bits separately; it is cleared on each state change.
- Illegal parameter values: elaboration-time error (generate-if with $error); no runtime handling.

Test Plan:
- CLKS_PER_BIT=4, 8N1, send 0x55 -> TxD 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; busy high 40 clocks; tx_ready low exactly those 40 clocks; TxD falls 1 clock after the transfer edge.
- PARITY=2, send 0x07 -> data bits 1,1,1,0,0,0,0,0 then parity 1, then stop; frame 44 clocks. Send 0x03 -> parity 0.
- PARITY=1, STOP_BITS=2, DATA_BITS=7, send 0x00 -> start, seven 0s, parity 1, stop high for 8 clocks; frame 44 clocks.
- tx_valid held high with words 0xA5 then 0x3C -> two correct frames; TxD high for exactly 1 clock between the end of the first stop bit and the second start bit; each word consumed exactly once.
- During a frame, pulse tx_valid with 0xFF and change tx_data -> frame in flight unchanged, 0xFF not transmitted, tx_ready stays 0.
- Assert reset low mid-DATA for 3 clocks, asynchronously off-edge -> TxD = 1, busy = 0, tx_ready = 1 immediately. After release, a new 0x81 frame transmits correctly from its start bit.
